// File: rtl/mc_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS-subset controller.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  // Instruction opcodes
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes
  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Datapath select encodings
  localparam logic [1:0] NPC_ADD4    = 2'd0;
  localparam logic [1:0] NPC_JUMP    = 2'd1;
  localparam logic [1:0] NPC_BRANCH  = 2'd2;
  localparam logic [1:0] NPC_JR      = 2'd3;
  localparam logic [1:0] EXT_UNSIGNED = 2'd0;
  localparam logic [1:0] EXT_SIGNED   = 2'd1;
  localparam logic [1:0] EXT_LUI      = 2'd2;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LT  = 3'd3;
  localparam logic [2:0] ALU_B   = 3'd4;
  localparam logic [1:0] REGDST_A3 = 2'd0;
  localparam logic [1:0] REGDST_A2 = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;
  localparam logic [1:0] DSRC_ALU = 2'd0;
  localparam logic [1:0] DSRC_DM  = 2'd1;
  localparam logic [1:0] DSRC_IFU = 2'd2;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_BR   = 4'd3,
    S_JMP  = 4'd4,
    S_MEM  = 4'd5,
    S_WB   = 4'd6,
    S_HALT = 4'd7
  } state_e;

  // Class picks the state that follows S_ID
  typedef enum logic [1:0] {CLS_NOP, CLS_EXE, CLS_BR, CLS_JMP} cls_e;

  // One-hot instruction bit positions; nop is the all-zero vector.
  // The eight S_EX instructions occupy the low bits contiguously.
  localparam int IX_ADDU  = 0;
  localparam int IX_SUBU  = 1;
  localparam int IX_SLT   = 2;
  localparam int IX_ADDIU = 3;
  localparam int IX_ORI   = 4;
  localparam int IX_LUI   = 5;
  localparam int IX_LW    = 6;
  localparam int IX_SW    = 7;
  localparam int IX_BEQ   = 8;
  localparam int IX_J     = 9;
  localparam int IX_JAL   = 10;
  localparam int IX_JR    = 11;
  localparam int N_INSTR  = 12;

  typedef logic [N_INSTR-1:0] instr_oh_t;

  function automatic logic is_rtype_alu(instr_oh_t oh);
    return oh[IX_ADDU] | oh[IX_SUBU] | oh[IX_SLT];
  endfunction

  function automatic logic uses_imm(instr_oh_t oh);
    return oh[IX_ADDIU] | oh[IX_ORI] | oh[IX_LUI] | oh[IX_LW] | oh[IX_SW];
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Purpose: controller <-> datapath/memory bundle; master = controller side.
// Latency: n/a (wires only).
// Backpressure: im_ready/dm_ready stall the controller in S_IF/S_MEM.
// Ports: IR fields + flags + readys in; requests, enables, selects, status out.
interface mc_ctrl_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       zero;
  logic       im_ready;
  logic       dm_ready;
  logic       im_req;
  logic       dm_req;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [1:0] NPC_Sel;
  logic [1:0] ExtOp;
  logic       ALUSrc;
  logic [2:0] ALUOp;
  logic [1:0] RegDst;
  logic [1:0] DataSrc;
  logic [3:0] state;
  logic       illegal;
  logic       bus_err;

  modport master (
    input  OpCode, Funct, zero, im_ready, dm_ready,
    output im_req, dm_req, PCWrite, IRWrite, RegWrite, MemWrite,
           NPC_Sel, ExtOp, ALUSrc, ALUOp, RegDst, DataSrc, state, illegal, bus_err
  );

  modport slave (
    output OpCode, Funct, zero, im_ready, dm_ready,
    input  im_req, dm_req, PCWrite, IRWrite, RegWrite, MemWrite,
           NPC_Sel, ExtOp, ALUSrc, ALUOp, RegDst, DataSrc, state, illegal, bus_err
  );
endinterface

// File: rtl/mc_decode.sv
// Purpose: OpCode/Funct -> instruction class, one-hot instruction, illegal flag.
// Latency: combinational.
// Backpressure: none.
// Ports: op_code, funct in; cls, instr_oh, illegal out.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output cls_e       cls,
  output instr_oh_t  instr_oh,
  output logic       illegal
);

  always_comb begin
    instr_oh = '0;
    illegal  = 1'b0;
    cls      = CLS_NOP;
    case (op_code)
      OP_R: begin
        case (funct)
          FN_NOP:  instr_oh = '0;
          FN_JR:   instr_oh[IX_JR]   = 1'b1;
          FN_ADDU: instr_oh[IX_ADDU] = 1'b1;
          FN_SUBU: instr_oh[IX_SUBU] = 1'b1;
          FN_SLT:  instr_oh[IX_SLT]  = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_BEQ:   instr_oh[IX_BEQ]   = 1'b1;
      OP_ADDIU: instr_oh[IX_ADDIU] = 1'b1;
      OP_ORI:   instr_oh[IX_ORI]   = 1'b1;
      OP_LUI:   instr_oh[IX_LUI]   = 1'b1;
      OP_LW:    instr_oh[IX_LW]    = 1'b1;
      OP_SW:    instr_oh[IX_SW]    = 1'b1;
      OP_J:     instr_oh[IX_J]     = 1'b1;
      OP_JAL:   instr_oh[IX_JAL]   = 1'b1;
      default:  illegal = 1'b1;
    endcase

    // Illegal encodings leave instr_oh at zero, so they fall out as nop.
    if (|instr_oh[IX_SW:IX_ADDU]) begin
      cls = CLS_EXE;
    end else if (instr_oh[IX_BEQ]) begin
      cls = CLS_BR;
    end else if (instr_oh[IX_J] | instr_oh[IX_JAL] | instr_oh[IX_JR]) begin
      cls = CLS_JMP;
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Purpose: multi-cycle controller FSM (IF/ID/EX/BR/JMP/MEM/WB/HALT) with bus timeout.
// Latency: nop 2, beq/j/jal/jr 3, ALU/sw 4, lw 5 cycles with readys high.
// Backpressure: waits in S_IF/S_MEM for ready; TIMEOUT straight misses -> sticky bus_err, S_HALT.
// Ports: clk, rst_n (async active-low), bus (mc_ctrl_if.master).
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst_n,
  mc_ctrl_if.master bus
);

  localparam int WW = $clog2(TIMEOUT + 1);
  // A miss on the cycle the counter already holds this value is the TIMEOUT-th miss
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  instr_oh_t     instr_q, instr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          bus_err_q, bus_err_d;

  cls_e      dec_cls;
  instr_oh_t dec_oh;
  logic      dec_illegal;

  logic       im_req, dm_req, pc_write, ir_write, reg_write, mem_write;
  logic [1:0] npc_sel, ext_op, reg_dst, data_src;
  logic       alu_src, illegal;
  logic [2:0] alu_op;

  mc_decode u_decode (
    .op_code  (bus.OpCode),
    .funct    (bus.Funct),
    .cls      (dec_cls),
    .instr_oh (dec_oh),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    wait_d    = '0;         // any ready or state change clears the miss count
    bus_err_d = bus_err_q;
    im_req    = 1'b0;
    dm_req    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    npc_sel   = NPC_ADD4;
    ext_op    = EXT_UNSIGNED;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    reg_dst   = REGDST_A3;
    data_src  = DSRC_ALU;
    illegal   = 1'b0;

    // Outputs go quiet the instant reset asserts, not at the next edge;
    // otherwise S_IF would still present im_req/IRWrite during reset.
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          im_req = 1'b1;
          if (bus.im_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            npc_sel  = NPC_ADD4;
            state_d  = S_ID;
          end else if (wait_q == WAIT_LAST) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_ID: begin
          illegal = dec_illegal;
          instr_d = dec_oh;   // held so later states don't depend on the IR
          case (dec_cls)
            CLS_EXE: state_d = S_EX;
            CLS_BR:  state_d = S_BR;
            CLS_JMP: state_d = S_JMP;
            default: state_d = S_IF;
          endcase
        end
        S_EX: begin
          alu_src = uses_imm(instr_q);
          if (instr_q[IX_SUBU])      alu_op = ALU_SUB;
          else if (instr_q[IX_ORI])  alu_op = ALU_OR;
          else if (instr_q[IX_SLT])  alu_op = ALU_LT;
          else if (instr_q[IX_LUI])  alu_op = ALU_B;
          else                       alu_op = ALU_ADD;
          if (instr_q[IX_ADDIU] | instr_q[IX_LW] | instr_q[IX_SW]) ext_op = EXT_SIGNED;
          else if (instr_q[IX_LUI])                                 ext_op = EXT_LUI;
          else                                                      ext_op = EXT_UNSIGNED;
          state_d = (instr_q[IX_LW] | instr_q[IX_SW]) ? S_MEM : S_WB;
        end
        S_MEM: begin
          dm_req    = 1'b1;
          mem_write = instr_q[IX_SW];
          if (bus.dm_ready) begin
            state_d = instr_q[IX_SW] ? S_IF : S_WB;
          end else if (wait_q == WAIT_LAST) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          if (instr_q[IX_LW]) begin
            reg_dst  = REGDST_A2;
            data_src = DSRC_DM;
          end else if (is_rtype_alu(instr_q)) begin
            reg_dst  = REGDST_A3;
            data_src = DSRC_ALU;
          end else begin
            reg_dst  = REGDST_A2;
            data_src = DSRC_ALU;
          end
          state_d = S_IF;
        end
        S_BR: begin
          alu_op   = ALU_SUB;
          alu_src  = 1'b0;
          npc_sel  = NPC_BRANCH;
          pc_write = bus.zero & instr_q[IX_BEQ];
          state_d  = S_IF;
        end
        S_JMP: begin
          pc_write = instr_q[IX_J] | instr_q[IX_JAL] | instr_q[IX_JR];
          npc_sel  = instr_q[IX_JR] ? NPC_JR : NPC_JUMP;
          if (instr_q[IX_JAL]) begin
            reg_write = 1'b1;
            reg_dst   = REGDST_RA;
            data_src  = DSRC_IFU;
          end
          state_d = S_IF;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      instr_q   <= '0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.im_req   = im_req;
  assign bus.dm_req   = dm_req;
  assign bus.PCWrite  = pc_write;
  assign bus.IRWrite  = ir_write;
  assign bus.RegWrite = reg_write;
  assign bus.MemWrite = mem_write;
  assign bus.NPC_Sel  = npc_sel;
  assign bus.ExtOp    = ext_op;
  assign bus.ALUSrc   = alu_src;
  assign bus.ALUOp    = alu_op;
  assign bus.RegDst   = reg_dst;
  assign bus.DataSrc  = data_src;
  assign bus.state    = state_q;
  assign bus.illegal  = illegal;
  assign bus.bus_err  = bus_err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Purpose: directed scoreboard bench for mc_ctrl (TIMEOUT=16 and TIMEOUT=4 instances).
// Latency: expected per-cycle output vectors queued by the driver, popped at negedge.
// Backpressure: readys driven per cycle by the stimulus.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst_n, rst_n_b;
  logic done, done_seen;
  always #5 clk = ~clk;

  mc_ctrl_if if_a();
  mc_ctrl_if if_b();

  mc_ctrl #(.TIMEOUT(16)) dut_a (.clk(clk), .rst_n(rst_n),   .bus(if_a.master));
  mc_ctrl #(.TIMEOUT(4))  dut_b (.clk(clk), .rst_n(rst_n_b), .bus(if_b.master));

  typedef struct packed {
    logic [3:0] st;
    logic       im_req, dm_req, pcw, irw, rgw, mw;
    logic [1:0] npc, ext;
    logic       src;
    logic [2:0] alu;
    logic [1:0] rd, ds;
    logic       ill, berr;
  } obs_t;

  obs_t  act_a, act_b, exp_o;
  string exp_nm;
  obs_t  q_a[$], q_b[$];
  string nm_a[$], nm_b[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  assign act_a = {if_a.state, if_a.im_req, if_a.dm_req, if_a.PCWrite, if_a.IRWrite,
                  if_a.RegWrite, if_a.MemWrite, if_a.NPC_Sel, if_a.ExtOp, if_a.ALUSrc,
                  if_a.ALUOp, if_a.RegDst, if_a.DataSrc, if_a.illegal, if_a.bus_err};
  assign act_b = {if_b.state, if_b.im_req, if_b.dm_req, if_b.PCWrite, if_b.IRWrite,
                  if_b.RegWrite, if_b.MemWrite, if_b.NPC_Sel, if_b.ExtOp, if_b.ALUSrc,
                  if_b.ALUOp, if_b.RegDst, if_b.DataSrc, if_b.illegal, if_b.bus_err};

  // ---------------- expected-vector builders (hand encodings) ----------------
  function automatic obs_t e_rst();
    obs_t o; o = '0; return o;
  endfunction
  function automatic obs_t e_if(logic r);
    obs_t o; o = '0; o.st = 4'd0; o.im_req = 1'b1; o.irw = r; o.pcw = r; return o;
  endfunction
  function automatic obs_t e_id(logic ill);
    obs_t o; o = '0; o.st = 4'd1; o.ill = ill; return o;
  endfunction
  function automatic obs_t e_ex(logic [2:0] alu, logic src, logic [1:0] ext);
    obs_t o; o = '0; o.st = 4'd2; o.alu = alu; o.src = src; o.ext = ext; return o;
  endfunction
  function automatic obs_t e_mem(logic wr);
    obs_t o; o = '0; o.st = 4'd5; o.dm_req = 1'b1; o.mw = wr; return o;
  endfunction
  function automatic obs_t e_wb(logic [1:0] rd, logic [1:0] ds);
    obs_t o; o = '0; o.st = 4'd6; o.rgw = 1'b1; o.rd = rd; o.ds = ds; return o;
  endfunction
  function automatic obs_t e_br(logic z);
    obs_t o; o = '0; o.st = 4'd3; o.alu = 3'd1; o.npc = 2'd2; o.pcw = z; return o;
  endfunction
  function automatic obs_t e_jmp(logic [1:0] npc, logic link);
    obs_t o; o = '0; o.st = 4'd4; o.pcw = 1'b1; o.npc = npc;
    if (link) begin o.rgw = 1'b1; o.rd = 2'd2; o.ds = 2'd2; end
    return o;
  endfunction
  function automatic obs_t e_halt();
    obs_t o; o = '0; o.st = 4'd7; o.berr = 1'b1; return o;
  endfunction

  // ---------------- drivers: queue expectation, apply inputs, advance ----------
  task automatic sa(obs_t e, string nm, logic ir, logic dr, logic z);
    q_a.push_back(e); nm_a.push_back(nm);
    if_a.im_ready = ir; if_a.dm_ready = dr; if_a.zero = z;
    @(posedge clk); #1;
  endtask
  task automatic sb(obs_t e, string nm, logic ir, logic dr, logic z);
    q_b.push_back(e); nm_b.push_back(nm);
    if_b.im_ready = ir; if_b.dm_ready = dr; if_b.zero = z;
    @(posedge clk); #1;
  endtask
  task automatic set_a(logic [5:0] op, logic [5:0] fn);
    if_a.OpCode = op; if_a.Funct = fn;
  endtask
  task automatic set_b(logic [5:0] op, logic [5:0] fn);
    if_b.OpCode = op; if_b.Funct = fn;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(obs_t act, obs_t exp, string nm);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h (state %0d) required %h (state %0d)",
               nm, act, act.st, exp, exp.st);
    end
  endtask

  initial begin
    done_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        exp_o = q_a.pop_front(); exp_nm = nm_a.pop_front();
        check(act_a, exp_o, exp_nm);
      end
      if (q_b.size() > 0) begin
        exp_o = q_b.pop_front(); exp_nm = nm_b.pop_front();
        check(act_b, exp_o, exp_nm);
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        n_cmp++;
        if (q_a.size() + q_b.size() != 0) begin
          n_bad++;
          $display("FAIL drain: actual %0d pending required 0", q_a.size() + q_b.size());
        end
      end
    end
  end

  // ---------------- ALU instruction table ----------------
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] alu;
    logic       src;
    logic [1:0] ext;
    logic [1:0] rd;
  } alu_vec_t;
  alu_vec_t av[6];

  initial begin
    av[0] = '{6'h00, 6'h21, 3'd0, 1'b0, 2'd0, 2'd0};  // addu
    av[1] = '{6'h00, 6'h23, 3'd1, 1'b0, 2'd0, 2'd0};  // subu
    av[2] = '{6'h00, 6'h2A, 3'd3, 1'b0, 2'd0, 2'd0};  // slt
    av[3] = '{6'h09, 6'h21, 3'd0, 1'b1, 2'd1, 2'd1};  // addiu (funct ignored)
    av[4] = '{6'h0D, 6'h00, 3'd2, 1'b1, 2'd0, 2'd1};  // ori
    av[5] = '{6'h0F, 6'h00, 3'd4, 1'b1, 2'd2, 2'd1};  // lui

    done = 1'b0; rst_n = 1'b0; rst_n_b = 1'b0;
    set_a(6'h00, 6'h00); set_b(6'h00, 6'h00);
    if_a.im_ready = 1'b1; if_a.dm_ready = 1'b0; if_a.zero = 1'b0;
    if_b.im_ready = 1'b0; if_b.dm_ready = 1'b0; if_b.zero = 1'b0;
    @(posedge clk); #1;

    // reset with im_ready high: everything quiet, state S_IF
    sa(e_rst(), "reset0", 1, 1, 0);
    sa(e_rst(), "reset1", 1, 1, 0);
    rst_n = 1'b1;

    // lw: IF ID EX MEM WB
    set_a(6'h23, 6'h00);
    sa(e_if(1), "lw_if", 1, 1, 0);
    sa(e_id(0), "lw_id", 1, 1, 0);
    sa(e_ex(3'd0, 1'b1, 2'd1), "lw_ex", 1, 1, 0);
    sa(e_mem(0), "lw_mem", 1, 1, 0);
    sa(e_wb(2'd1, 2'd1), "lw_wb", 1, 1, 0);

    // R-type and I-type ALU: IF ID EX WB
    for (int i = 0; i < 6; i++) begin
      set_a(av[i].op, av[i].fn);
      sa(e_if(1), $sformatf("alu%0d_if", i), 1, 1, 0);
      sa(e_id(0), $sformatf("alu%0d_id", i), 1, 1, 0);
      sa(e_ex(av[i].alu, av[i].src, av[i].ext), $sformatf("alu%0d_ex", i), 1, 1, 0);
      sa(e_wb(av[i].rd, 2'd0), $sformatf("alu%0d_wb", i), 1, 1, 0);
    end

    // sw, ready immediately: IF ID EX MEM
    set_a(6'h2B, 6'h00);
    sa(e_if(1), "sw_if", 1, 1, 0);
    sa(e_id(0), "sw_id", 1, 1, 0);
    sa(e_ex(3'd0, 1'b1, 2'd1), "sw_ex", 1, 1, 0);
    sa(e_mem(1), "sw_mem", 1, 1, 0);

    // beq taken then not taken
    set_a(6'h04, 6'h00);
    sa(e_if(1), "beq1_if", 1, 1, 0);
    sa(e_id(0), "beq1_id", 1, 1, 0);
    sa(e_br(1), "beq_taken", 1, 1, 1);
    sa(e_if(1), "beq0_if", 1, 1, 0);
    sa(e_id(0), "beq0_id", 1, 1, 0);
    sa(e_br(0), "beq_not", 1, 1, 0);

    // j, jal, jr
    set_a(6'h02, 6'h00);
    sa(e_if(1), "j_if", 1, 1, 0);
    sa(e_id(0), "j_id", 1, 1, 0);
    sa(e_jmp(2'd1, 1'b0), "j_jmp", 1, 1, 0);
    set_a(6'h03, 6'h00);
    sa(e_if(1), "jal_if", 1, 1, 0);
    sa(e_id(0), "jal_id", 1, 1, 0);
    sa(e_jmp(2'd1, 1'b1), "jal_jmp", 1, 1, 0);
    set_a(6'h00, 6'h08);
    sa(e_if(1), "jr_if", 1, 1, 0);
    sa(e_id(0), "jr_id", 1, 1, 0);
    sa(e_jmp(2'd3, 1'b0), "jr_jmp", 1, 1, 0);

    // nop, illegal opcode, illegal funct: 2 cycles each, no write enables
    set_a(6'h00, 6'h00);
    sa(e_if(1), "nop_if", 1, 1, 0);
    sa(e_id(0), "nop_id", 1, 1, 0);
    set_a(6'h3F, 6'h00);
    sa(e_if(1), "illop_if", 1, 1, 0);
    sa(e_id(1), "illop_id", 1, 1, 0);
    set_a(6'h00, 6'h3F);
    sa(e_if(1), "illfn_if", 1, 1, 0);
    sa(e_id(1), "illfn_id", 1, 1, 0);

    // fetch stalled 3 cycles
    set_a(6'h00, 6'h00);
    for (int i = 0; i < 3; i++) sa(e_if(0), "if_stall", 0, 1, 0);
    sa(e_if(1), "if_go", 1, 1, 0);
    sa(e_id(0), "if_go_id", 1, 1, 0);

    // sw with dm_ready low 5 cycles: MemWrite held 6 cycles, no error
    set_a(6'h2B, 6'h00);
    sa(e_if(1), "swst_if", 1, 1, 0);
    sa(e_id(0), "swst_id", 1, 1, 0);
    sa(e_ex(3'd0, 1'b1, 2'd1), "swst_ex", 1, 1, 0);
    for (int i = 0; i < 5; i++) sa(e_mem(1), "swst_wait", 1, 0, 0);
    sa(e_mem(1), "swst_done", 1, 1, 0);

    // reset in the middle of a stalled lw access
    set_a(6'h23, 6'h00);
    sa(e_if(1), "lwr_if", 1, 1, 0);
    sa(e_id(0), "lwr_id", 1, 1, 0);
    sa(e_ex(3'd0, 1'b1, 2'd1), "lwr_ex", 1, 1, 0);
    sa(e_mem(0), "lwr_mem0", 1, 0, 0);
    sa(e_mem(0), "lwr_mem1", 1, 0, 0);
    rst_n = 1'b0;
    sa(e_rst(), "rst_mid", 1, 1, 0);
    rst_n = 1'b1;
    set_a(6'h00, 6'h00);
    sa(e_if(1), "post_rst_if", 1, 1, 0);
    sa(e_id(0), "post_rst_id", 1, 1, 0);

    // ---- TIMEOUT=4 instance ----
    rst_n_b = 1'b1;
    set_b(6'h00, 6'h00);
    for (int i = 0; i < 3; i++) sb(e_if(0), "b_wait", 0, 0, 0);
    sb(e_if(1), "b_rdy_wins", 1, 0, 0);
    sb(e_id(0), "b_nop_id", 1, 0, 0);
    for (int i = 0; i < 3; i++) sb(e_if(0), "b_wait2", 0, 0, 0);
    sb(e_if(1), "b_wait_clr", 1, 0, 0);
    sb(e_id(0), "b_nop_id2", 1, 0, 0);

    // data-side timeout
    set_b(6'h2B, 6'h00);
    sb(e_if(1), "b_sw_if", 1, 0, 0);
    sb(e_id(0), "b_sw_id", 1, 0, 0);
    sb(e_ex(3'd0, 1'b1, 2'd1), "b_sw_ex", 1, 0, 0);
    for (int i = 0; i < 4; i++) sb(e_mem(1), "b_sw_wait", 1, 0, 0);
    sb(e_halt(), "b_mem_to", 1, 1, 0);
    sb(e_halt(), "b_halt_stuck", 1, 1, 0);
    rst_n_b = 1'b0;
    sb(e_rst(), "b_rst1", 0, 0, 0);
    rst_n_b = 1'b1;

    // fetch-side timeout
    set_b(6'h00, 6'h00);
    for (int i = 0; i < 4; i++) sb(e_if(0), "b_if_wait", 0, 0, 0);
    sb(e_halt(), "b_if_to", 1, 1, 0);
    sb(e_halt(), "b_if_stuck", 1, 1, 0);
    rst_n_b = 1'b0;
    sb(e_rst(), "b_rst2", 0, 0, 0);
    rst_n_b = 1'b1;
    sb(e_if(0), "b_after_rst", 0, 0, 0);

    done = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
